// File: rtl/data_mem_ctrl.sv
// ============================================================================
// data_mem_ctrl : data-side load/store responder with posted in-order write
//                 buffer in front of a req/ack word bus
// Revision      : 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
    parameter int WB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_sz,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_HOLD  = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [29:0]        wb_addr_q  [WB_DEPTH];
    logic [29:0]        wb_addr_d  [WB_DEPTH];
    logic [3:0]         wb_be_q    [WB_DEPTH];
    logic [3:0]         wb_be_d    [WB_DEPTH];
    logic [31:0]        wb_wdata_q [WB_DEPTH];
    logic [31:0]        wb_wdata_d [WB_DEPTH];
    logic [29:0]        pend_addr_q, pend_addr_d;
    logic [3:0]         pend_be_q, pend_be_d;
    logic [31:0]        pend_wdata_q, pend_wdata_d;
    logic [29:0]        ld_addr_q, ld_addr_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [3:0]         st_be;
    logic [31:0]        st_wdata;
    logic               drain_active;
    logic               pop;
    logic               full;
    logic               push;
    logic [29:0]        push_addr;
    logic [3:0]         push_be;
    logic [31:0]        push_wdata;

    // Store lane steering, applied once at enqueue time
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = data_wdata;
        case (data_sz)
            2'd0: begin
                st_be    = 4'b0001 << data_addr[1:0];
                st_wdata = {24'd0, data_wdata[7:0]} << {data_addr[1:0], 3'b000};
            end
            2'd1: begin
                st_be    = data_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = data_addr[1] ? {data_wdata[15:0], 16'd0}
                                        : {16'd0, data_wdata[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        drain_active = (count_q != '0) && (state_q != ST_RD_REQ);
        pop          = drain_active && mem_ack;
        full         = (count_q == CNT_W'(WB_DEPTH));

        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_be_d    = pend_be_q;
        pend_wdata_d = pend_wdata_q;
        ld_addr_d    = ld_addr_q;
        rdata_d      = rdata_q;
        push         = 1'b0;
        push_addr    = data_addr[31:2];
        push_be      = st_be;
        push_wdata   = st_wdata;

        case (state_q)
            ST_IDLE, ST_RD_DONE: begin
                state_d = ST_IDLE;
                if (data_r) begin
                    ld_addr_d = data_addr[31:2];
                    state_d   = (count_q == '0) ? ST_RD_REQ : ST_RD_DRAIN;
                end else if (data_w) begin
                    // A pop on this edge frees the slot the store needs
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        state_d      = ST_WR_HOLD;
                        pend_addr_d  = data_addr[31:2];
                        pend_be_d    = st_be;
                        pend_wdata_d = st_wdata;
                    end
                end
            end
            ST_WR_HOLD: begin
                if (pop) begin
                    push       = 1'b1;
                    push_addr  = pend_addr_q;
                    push_be    = pend_be_q;
                    push_wdata = pend_wdata_q;
                    state_d    = ST_IDLE;
                end
            end
            ST_RD_DRAIN: begin
                if ((count_q == '0) || (pop && (count_q == CNT_W'(1)))) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RD_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(WB_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(WB_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        wb_addr_d  = wb_addr_q;
        wb_be_d    = wb_be_q;
        wb_wdata_d = wb_wdata_q;
        if (push) begin
            wb_addr_d[wr_ptr_q]  = push_addr;
            wb_be_d[wr_ptr_q]    = push_be;
            wb_wdata_d[wr_ptr_q] = push_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            pend_addr_q  <= '0;
            pend_be_q    <= '0;
            pend_wdata_q <= '0;
            ld_addr_q    <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            pend_addr_q  <= pend_addr_d;
            pend_be_q    <= pend_be_d;
            pend_wdata_q <= pend_wdata_d;
            ld_addr_q    <= ld_addr_d;
            rdata_q      <= rdata_d;
        end
    end

    // Buffer storage is qualified by count, so it needs no reset
    always_ff @(posedge clk) begin
        wb_addr_q  <= wb_addr_d;
        wb_be_q    <= wb_be_d;
        wb_wdata_q <= wb_wdata_d;
    end

    always_comb begin
        data_busy  = (state_q == ST_WR_HOLD) || (state_q == ST_RD_DRAIN) ||
                     (state_q == ST_RD_REQ);
        data_rdata = rdata_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 30'd0;
        mem_wdata  = 32'd0;
        if (state_q == ST_RD_REQ) begin
            mem_req  = 1'b1;
            mem_be   = 4'b1111;
            mem_addr = ld_addr_q;
        end else if (drain_active) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_be    = wb_be_q[rd_ptr_q];
            mem_addr  = wb_addr_q[rd_ptr_q];
            mem_wdata = wb_wdata_q[rd_ptr_q];
        end
    end

endmodule

`default_nettype wire
